// File: rtl/dmem_block_mover.sv
// Block copy / constant fill engine that masters the data-memory port while the CPU stalls on busy.
// Latency: copy 2N+1 cycles, fill N+1, zero length 1; no backpressure, start is ignored while busy.
module dmem_block_mover #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

  logic [1:0]        state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic              mode_q;
  logic [DATA_W-1:0] fill_q;
  logic [DATA_W-1:0] data_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W-1:0]  idx_nxt;

  assign idx_nxt = idx + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      mode_q <= 1'b0;
      fill_q <= '0;
      data_q <= '0;
      len_q  <= '0;
      idx    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q  <= src_addr;
            dst_q  <= dst_addr;
            mode_q <= mode;
            fill_q <= fill_data;
            len_q  <= (length > MAX_LEN) ? MAX_LEN : length;
            idx    <= '0;
            if (length == '0)
              state <= S_FIN;
            else if (mode)
              state <= S_WR;
            else
              state <= S_RD;
          end
        end
        S_RD: begin
          data_q <= mem_read_data;
          state  <= S_WR;
        end
        S_WR: begin
          idx <= idx_nxt;
          // Ascending byte-at-a-time order: overlapping copies re-read freshly written bytes.
          if (idx_nxt == len_q)
            state <= S_FIN;
          else
            state <= mode_q ? S_WR : S_RD;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from state only, so async reset drops mem_write without a clock edge.
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    case (state)
      S_RD: begin
        busy        = 1'b1;
        mem_read    = 1'b1;
        mem_address = src_q + idx[ADDR_W-1:0];
      end
      S_WR: begin
        busy           = 1'b1;
        mem_write      = 1'b1;
        mem_address    = dst_q + idx[ADDR_W-1:0];
        mem_write_data = mode_q ? fill_q : data_q;
      end
      S_FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_block_mover.sv
// Bench for dmem_block_mover: vector table of transfers plus a reset-abort sequence,
// with an ordered scoreboard of expected memory reads/writes.
module tb_dmem_block_mover;

  typedef struct {
    logic        mode;
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [8:0]  len;
    logic [7:0]  fill;
    bit          poke;
    int          exp_cyc;
    logic [7:0]  chk_addr;
    int          chk_n;
    logic [31:0] chk;
  } vec_t;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
  } op_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] src_addr = '0;
  logic [7:0] dst_addr = '0;
  logic [8:0] length = '0;
  logic [7:0] fill_data = '0;
  logic       busy, done, mem_write, mem_read;
  logic [7:0] mem_address, mem_write_data, mem_read_data;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       pl_we = 1'b0;
  logic [7:0] pl_a = '0;
  logic [7:0] pl_d = '0;
  op_t        exp_q [$];
  vec_t       tv [6];

  always #5 clk = ~clk;

  dmem_block_mover #(.ADDR_W(8), .DATA_W(8), .LEN_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_data(fill_data),
    .busy(busy), .done(done), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_write_data;
    else if (pl_we) mem[pl_a] <= pl_d;
  end
  assign mem_read_data = mem_read ? mem[mem_address] : 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every memory op the DUT issues must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read && mem_write) check("rd_wr_overlap", 32'd1, 32'd0);
      if (mem_read || mem_write) begin
        if (exp_q.size() == 0) begin
          check("unexpected_op", {23'd0, mem_write, mem_address}, 32'hFFFF_FFFF);
        end else begin
          op_t e;
          e = exp_q.pop_front();
          check("op_kind", {31'd0, mem_write}, {31'd0, e.wr});
          check("op_addr", {24'd0, mem_address}, {24'd0, e.addr});
          if (e.wr) check("op_data", {24'd0, mem_write_data}, {24'd0, e.data});
        end
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    ref_mem[a] = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic build_ops(input vec_t v, input bit upd_ref);
    int n;
    logic [7:0] s, d, val;
    n = (v.len > 9'd256) ? 256 : int'(v.len);
    for (int i = 0; i < n; i++) begin
      s = v.src + 8'(i);
      d = v.dst + 8'(i);
      if (v.mode) begin
        val = v.fill;
      end else begin
        exp_q.push_back('{wr: 1'b0, addr: s, data: 8'h00});
        val = ref_mem[s];
      end
      if (upd_ref) ref_mem[d] = val;
      exp_q.push_back('{wr: 1'b1, addr: d, data: val});
    end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int cycles, done_cnt, done_at, bad, act;
    logic [7:0] a;
    build_ops(v, 1'b1);
    @(negedge clk);
    mode = v.mode; src_addr = v.src; dst_addr = v.dst; length = v.len; fill_data = v.fill;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = ~v.mode; src_addr = 8'($urandom); dst_addr = 8'($urandom);
    length = 9'($urandom); fill_data = 8'($urandom);
    check($sformatf("v%0d_busy_rise", k), {31'd0, busy}, 32'd1);
    cycles = 0; done_cnt = 0; done_at = 0;
    while (busy && cycles < 1000) begin
      cycles++;
      if (done) begin done_cnt++; done_at = cycles; end
      start = v.poke && (cycles == 5);
      @(negedge clk);
    end
    start = 1'b0;
    if (cycles >= 1000) check($sformatf("v%0d_timeout", k), 32'd1, 32'd0);
    check($sformatf("v%0d_busy_cycles", k), cycles, v.exp_cyc);
    check($sformatf("v%0d_done_count", k), done_cnt, 1);
    check($sformatf("v%0d_done_at", k), done_at, v.exp_cyc);
    check($sformatf("v%0d_ops_left", k), exp_q.size(), 0);
    exp_q.delete();
    act = 0;
    repeat (4) begin
      if (busy || done) act++;
      @(negedge clk);
    end
    check($sformatf("v%0d_idle_after", k), act, 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check($sformatf("v%0d_mem_model", k), bad, 0);
    for (int i = 0; i < v.chk_n; i++) begin
      a = v.chk_addr + 8'(i);
      check($sformatf("v%0d_byte_%0h", k, a), {24'd0, mem[a]}, {24'd0, v.chk[31-8*i -: 8]});
    end
  endtask

  initial begin
    vec_t rv;
    int act;
    // mode src dst len fill poke cycles chk_addr chk_n chk
    tv[0] = '{1'b0, 8'h10, 8'h80, 9'd4,     8'h00, 1'b0, 9,   8'h80, 4, 32'hA1B2C3D4};
    tv[1] = '{1'b1, 8'h00, 8'hFE, 9'd4,     8'h5A, 1'b0, 5,   8'hFE, 4, 32'h5A5A5A5A};
    tv[2] = '{1'b0, 8'h30, 8'h90, 9'd0,     8'h77, 1'b0, 1,   8'h90, 0, 32'h0};
    tv[3] = '{1'b0, 8'h20, 8'h21, 9'd3,     8'h00, 1'b0, 7,   8'h21, 3, 32'h01010100};
    tv[4] = '{1'b0, 8'hFE, 8'h40, 9'd5,     8'h00, 1'b0, 11,  8'h40, 4, 32'h5A5A5A5A};
    tv[5] = '{1'b1, 8'h00, 8'h00, 9'h1FF,   8'h00, 1'b1, 257, 8'h80, 4, 32'h00000000};

    repeat (2) @(negedge clk);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_done",  {31'd0, done},      32'd0);
    check("rst_mem_wr", {31'd0, mem_write}, 32'd0);
    check("rst_mem_rd", {31'd0, mem_read},  32'd0);
    check("rst_addr",  {24'd0, mem_address}, 32'd0);

    for (int i = 0; i < 256; i++) preload(8'(i), 8'(i * 7 + 3));
    preload(8'h10, 8'hA1); preload(8'h11, 8'hB2); preload(8'h12, 8'hC3); preload(8'h13, 8'hD4);
    preload(8'h20, 8'h01); preload(8'h21, 8'h02); preload(8'h22, 8'h03); preload(8'h23, 8'h04);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 6; k++) run_vec(k, tv[k]);

    // Abort a fill mid-write with async reset.
    rv = '{1'b1, 8'h00, 8'h60, 9'd10, 8'hEE, 1'b0, 11, 8'h60, 0, 32'h0};
    build_ops(rv, 1'b0);
    mode = 1'b1; dst_addr = 8'h60; length = 9'd10; fill_data = 8'hEE;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    check("abort_pre_write", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_write", {31'd0, mem_write}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || done || mem_read || mem_write) act++;
    end
    check("abort_idle_after", act, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_block_mover.md
Name: dmem_block_mover

Overview:
- Bus-master engine that initiates transfers on the data memory port (address, writeData, memWrite, memRead → readData).
- Copies a block of bytes from one data-memory region to another, or fills a region with a constant byte.
- Sits between the CPU and data memory. The CPU programs it, pulses start, and stalls on busy while the engine owns the memory port.

Parameters:
- ADDR_W, 8, data-memory address width (memory depth 2^ADDR_W)
- DATA_W, 8, data word width
- LEN_W, 9, transfer length width; must be ADDR_W+1 so a full 256-byte transfer is expressible

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill
- src_addr  in  ADDR_W  copy source base address (ignored in fill)
- dst_addr  in  ADDR_W  destination base address
- length  in  LEN_W  number of bytes to move
- fill_data  in  DATA_W  fill byte (ignored in copy)
- busy  out  1  engine owns the memory port; CPU must hold off
- done  out  1  one-cycle completion pulse
- mem_address  out  ADDR_W  to memory address
- mem_write_data  out  DATA_W  to memory writeData
- mem_write  out  1  to memory memWrite
- mem_read  out  1  to memory memRead
- mem_read_data  in  DATA_W  from memory readData (combinational while mem_read=1)

Behaviour:
- States:
  - IDLE: no activity.
  - RD: drive the source read.
  - WR: drive the destination write.
  - FIN: signal completion.
- Reset, asynchronous, any state:
  - State → IDLE; all outputs 0; internal counters and data latch cleared.
  - mem_write drops immediately, so no partial write is issued.
- IDLE:
  - busy=0, done=0, mem_* = 0.
  - On a clock edge with start=1, latch src_addr, dst_addr, mode, fill_data, and length (saturated to 2^ADDR_W if larger).
  - Next state:
    - length==0 → FIN.
    - mode=0 → RD.
    - mode=1 → WR.
- RD (copy only):
  - mem_read=1, mem_address=src+idx, mem_write=0.
  - At the clock edge, latch mem_read_data into the data register, then → WR.
- WR:
  - mem_write=1, mem_read=0, mem_address=dst+idx.
  - mem_write_data = data register (copy) or latched fill byte (fill).
  - At the edge: idx+1. If idx+1==len → FIN, else → RD (copy) or stay in WR (fill).
- FIN: done=1, busy=1, mem_* = 0; → IDLE next edge.
- busy=1 in RD, WR and FIN; it rises the cycle after start is sampled.
- Addresses: src+idx and dst+idx wrap modulo 2^ADDR_W.
- Timing:
  - Copy of N bytes: 2N cycles in RD/WR, then 1 cycle in FIN.
  - Fill of N bytes: N cycles in WR, then 1 cycle in FIN.
- Copy order is strictly ascending, byte-at-a-time. With overlapping regions where dst>src, already-written bytes are re-read; this is the defined result.
- mem_read and mem_write are never high in the same cycle.
- start while busy is ignored; it is not queued.
- Input changes after the start edge have no effect on the transfer in progress.

Test Plan:
- Reset: rst_n=0 mid-WR → mem_write, busy and done go 0 without waiting for a clock edge; after release, state is IDLE and no further memory activity occurs.
- Copy: memory preloaded 0x10..0x13 = A1,B2,C3,D4; start with mode=0, src=0x10, dst=0x80, len=4 →
  - memory 0x80..0x83 = A1,B2,C3,D4;
  - busy high for exactly 9 cycles;
  - done pulses once on the 9th busy cycle;
  - the mem_read/mem_write pattern alternates R,W,R,W,…
- Fill with wrap: mode=1, dst=0xFE, len=4, fill_data=0x5A → bytes 0xFE, 0xFF, 0x00, 0x01 = 5A; 4 WR cycles, then FIN.
- Zero length: len=0 → no mem_read/mem_write activity; busy and done high for 1 cycle, the cycle after start.
- Full size and busy-start: len=0x1FF (saturates to 256), fill 0x00 → all 256 bytes written. A second start pulse while busy is ignored: exactly one done pulse occurs.
- Overlap: preload 0x20..0x23 = 01,02,03,04; copy src=0x20, dst=0x21, len=3 → 0x21..0x23 = 01,01,01.
